// File: rtl/ser_frame_rx.sv
// Serial frame receiver: hunts for preamble 0xAB / SFD 0x28, collects src, dst,
// stype and 16-bit data MSB first, and presents the packet with valid/ready handshake.
module ser_frame_rx #(
  parameter int unsigned STYPE_MAX = 9
) (
  input  logic        ser_clk,
  input  logic        reset,
  input  logic        ser_in,
  output logic [7:0]  pkt_src,
  output logic [7:0]  pkt_dst,
  output logic [7:0]  pkt_stype,
  output logic [15:0] pkt_data,
  output logic        pkt_valid,
  input  logic        pkt_ready,
  output logic [7:0]  frame_cnt,
  output logic [7:0]  err_cnt,
  output logic        overflow
);

  typedef enum logic [2:0] {
    HUNT  = 3'd0,
    SFD   = 3'd1,
    SRC   = 3'd2,
    DST   = 3'd3,
    STYPE = 3'd4,
    DATA  = 3'd5,
    CHECK = 3'd6
  } state_t;

  localparam logic [7:0] STYPE_LIM = 8'(STYPE_MAX);

  state_t      state_r, state_s;
  logic [3:0]  cnt_r, cnt_s;
  logic [7:0]  sreg_r;
  logic [7:0]  byte_s;
  logic        byte_done_s;
  logic        sfd_err_s;
  logic [7:0]  src_cap_r, dst_cap_r, stype_cap_r;
  logic [15:0] data_cap_r;
  logic [7:0]  pkt_src_r, pkt_dst_r, pkt_stype_r;
  logic [15:0] pkt_data_r;
  logic        pkt_valid_r, overflow_r;
  logic [7:0]  frame_cnt_r, err_cnt_r;
  logic        accept_s, load_s, ovf_s, chk_err_s, err_inc_s;

  // The byte completing on this edge includes the bit being sampled now.
  assign byte_s      = {sreg_r[6:0], ser_in};
  assign byte_done_s = (cnt_r == 4'd7);
  assign accept_s    = pkt_valid_r & pkt_ready;

  // Next-state and bit-counter logic.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r + 4'd1;
    sfd_err_s = 1'b0;
    case (state_r)
      HUNT: begin
        cnt_s = 4'd0;
        if (byte_s == 8'hAB) state_s = SFD;
        else                 state_s = HUNT;
      end
      SFD: begin
        if (byte_done_s) begin
          cnt_s = 4'd0;
          if (byte_s == 8'h28) begin
            state_s = SRC;
          end else begin
            state_s   = HUNT;
            sfd_err_s = 1'b1;
          end
        end else begin
          state_s = SFD;
        end
      end
      SRC: begin
        if (byte_done_s) begin state_s = DST;   cnt_s = 4'd0; end
        else             begin state_s = SRC; end
      end
      DST: begin
        if (byte_done_s) begin state_s = STYPE; cnt_s = 4'd0; end
        else             begin state_s = DST; end
      end
      STYPE: begin
        if (byte_done_s) begin state_s = DATA;  cnt_s = 4'd0; end
        else             begin state_s = STYPE; end
      end
      DATA: begin
        if (cnt_r == 4'd15) begin state_s = CHECK; cnt_s = 4'd0; end
        else                begin state_s = DATA; end
      end
      CHECK: begin
        state_s = HUNT;
        cnt_s   = 4'd0;
      end
      default: begin
        state_s = HUNT;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // Frame disposition in CHECK: drop bad stype, load, or flag overflow.
  always_comb begin
    load_s    = 1'b0;
    ovf_s     = 1'b0;
    chk_err_s = 1'b0;
    if (state_r == CHECK) begin
      if (stype_cap_r > STYPE_LIM)          chk_err_s = 1'b1;
      else if (!pkt_valid_r || accept_s)    load_s    = 1'b1;
      else                                  ovf_s     = 1'b1;
    end else begin
      load_s    = 1'b0;
      ovf_s     = 1'b0;
      chk_err_s = 1'b0;
    end
  end

  // SFD and CHECK errors occur in different states, so at most one fires per edge.
  assign err_inc_s = sfd_err_s | chk_err_s | ovf_s;

  // State, shift register and field capture.
  always_ff @(posedge ser_clk) begin
    if (reset) begin
      state_r     <= HUNT;
      cnt_r       <= 4'd0;
      sreg_r      <= 8'd0;
      src_cap_r   <= 8'd0;
      dst_cap_r   <= 8'd0;
      stype_cap_r <= 8'd0;
      data_cap_r  <= 16'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      sreg_r  <= byte_s;
      case (state_r)
        SRC:     if (byte_done_s) src_cap_r   <= byte_s;
        DST:     if (byte_done_s) dst_cap_r   <= byte_s;
        STYPE:   if (byte_done_s) stype_cap_r <= byte_s;
        DATA:    data_cap_r <= {data_cap_r[14:0], ser_in};
        default: data_cap_r <= data_cap_r;
      endcase
    end
  end

  // Packet outputs, handshake and event counters.
  always_ff @(posedge ser_clk) begin
    if (reset) begin
      pkt_src_r   <= 8'd0;
      pkt_dst_r   <= 8'd0;
      pkt_stype_r <= 8'd0;
      pkt_data_r  <= 16'd0;
      pkt_valid_r <= 1'b0;
      overflow_r  <= 1'b0;
      frame_cnt_r <= 8'd0;
      err_cnt_r   <= 8'd0;
    end else begin
      if (load_s) begin
        pkt_src_r   <= src_cap_r;
        pkt_dst_r   <= dst_cap_r;
        pkt_stype_r <= stype_cap_r;
        pkt_data_r  <= data_cap_r;
        pkt_valid_r <= 1'b1;
        frame_cnt_r <= frame_cnt_r + 8'd1;
      end else if (accept_s) begin
        pkt_valid_r <= 1'b0;
      end
      overflow_r <= ovf_s;
      if (err_inc_s && (err_cnt_r != 8'hFF)) err_cnt_r <= err_cnt_r + 8'd1;
    end
  end

  assign pkt_src   = pkt_src_r;
  assign pkt_dst   = pkt_dst_r;
  assign pkt_stype = pkt_stype_r;
  assign pkt_data  = pkt_data_r;
  assign pkt_valid = pkt_valid_r;
  assign frame_cnt = frame_cnt_r;
  assign err_cnt   = err_cnt_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_ser_frame_rx.sv
// Directed self-checking bench for ser_frame_rx: single frame, back-to-back frames,
// bad SFD, bad stype, back-pressure/overflow and mid-frame reset.
module tb_ser_frame_rx;

  logic        ser_clk = 1'b0;
  logic        reset;
  logic        ser_in;
  logic [7:0]  pkt_src, pkt_dst, pkt_stype;
  logic [15:0] pkt_data;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [7:0]  frame_cnt, err_cnt;
  logic        overflow;

  int n_checks = 0;
  int n_pass   = 0;

  logic [39:0] cap_q[$];
  int          ovf_seen = 0;

  ser_frame_rx #(.STYPE_MAX(9)) dut (
    .ser_clk   (ser_clk),
    .reset     (reset),
    .ser_in    (ser_in),
    .pkt_src   (pkt_src),
    .pkt_dst   (pkt_dst),
    .pkt_stype (pkt_stype),
    .pkt_data  (pkt_data),
    .pkt_valid (pkt_valid),
    .pkt_ready (pkt_ready),
    .frame_cnt (frame_cnt),
    .err_cnt   (err_cnt),
    .overflow  (overflow)
  );

  always #5 ser_clk = ~ser_clk;

  // Record every transfer and overflow pulse using pre-edge values.
  always @(posedge ser_clk) begin
    if (pkt_valid && pkt_ready) cap_q.push_back({pkt_src, pkt_dst, pkt_stype, pkt_data});
    if (overflow) ovf_seen++;
  end

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_bit(input logic b);
    ser_in = b;
    @(negedge ser_clk);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic pad(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0);
  endtask

  task automatic send_frame(input logic [7:0] src, input logic [7:0] dst,
                            input logic [7:0] st, input logic [15:0] d);
    send_byte(8'hAB);
    send_byte(8'h28);
    send_byte(src);
    send_byte(dst);
    send_byte(st);
    send_byte(d[15:8]);
    send_byte(d[7:0]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pad(2);
    reset = 1'b0;
  endtask

  int base;
  int ovf_base;

  initial begin
    reset     = 1'b1;
    ser_in    = 1'b0;
    pkt_ready = 1'b1;
    @(negedge ser_clk);
    do_reset();

    // Reset state
    check("rst_valid", 40'(pkt_valid), 40'd0);
    check("rst_frame_cnt", 40'(frame_cnt), 40'd0);
    check("rst_err_cnt", 40'(err_cnt), 40'd0);
    check("rst_data", 40'(pkt_data), 40'd0);

    // Single frame and latency
    send_frame(8'hAA, 8'hAA, 8'h03, 16'h0001);
    check("lat_valid_lo", 40'(pkt_valid), 40'd0);
    send_bit(1'b0);
    check("lat_valid_hi", 40'(pkt_valid), 40'd1);
    check("single_pkt", {pkt_src, pkt_dst, pkt_stype, pkt_data}, 40'hAA_AA_03_0001);
    check("single_frame_cnt", 40'(frame_cnt), 40'd1);
    send_bit(1'b0);
    check("single_pulse_end", 40'(pkt_valid), 40'd0);

    // Continuous 16-byte frames, stype 0..3
    do_reset();
    base = cap_q.size();
    for (int k = 0; k < 4; k++) begin
      send_frame(8'h10 + 8'(k), 8'h20 + 8'(k), 8'(k), 16'h1000 + 16'(k));
      pad(72);
    end
    check("cont_count", 40'(cap_q.size() - base), 40'd4);
    if (cap_q.size() >= base + 4) begin
      for (int k = 0; k < 4; k++)
        check("cont_pkt", cap_q[base + k],
              {8'h10 + 8'(k), 8'h20 + 8'(k), 8'(k), 16'h1000 + 16'(k)});
    end
    check("cont_frame_cnt", 40'(frame_cnt), 40'd4);
    check("cont_err_cnt", 40'(err_cnt), 40'd0);

    // Bad SFD, then a good frame
    do_reset();
    base = cap_q.size();
    send_byte(8'hAB);
    send_byte(8'h29);
    for (int k = 0; k < 5; k++) send_byte(8'h00);
    pad(16);
    check("badsfd_err", 40'(err_cnt), 40'd1);
    check("badsfd_nopkt", 40'(cap_q.size() - base), 40'd0);
    check("badsfd_frame_cnt", 40'(frame_cnt), 40'd0);
    send_frame(8'hA1, 8'hB2, 8'h04, 16'hCAFE);
    pad(16);
    check("badsfd_next_count", 40'(cap_q.size() - base), 40'd1);
    if (cap_q.size() > base) check("badsfd_next_pkt", cap_q[base], 40'hA1_B2_04_CAFE);
    check("badsfd_next_frame_cnt", 40'(frame_cnt), 40'd1);

    // Bad stype 0x0A dropped; 0x09 is the highest legal value
    do_reset();
    base = cap_q.size();
    send_frame(8'h01, 8'h02, 8'h0A, 16'hBEEF);
    pad(16);
    check("badst_err", 40'(err_cnt), 40'd1);
    check("badst_frame_cnt", 40'(frame_cnt), 40'd0);
    check("badst_nopkt", 40'(cap_q.size() - base), 40'd0);
    send_frame(8'h03, 8'h04, 8'h09, 16'h0909);
    pad(16);
    check("maxst_frame_cnt", 40'(frame_cnt), 40'd1);
    if (cap_q.size() > base) check("maxst_pkt", cap_q[base], 40'h03_04_09_0909);
    else check("maxst_count", 40'(cap_q.size() - base), 40'd1);

    // Back-pressure: second frame dropped with overflow
    do_reset();
    ovf_base  = ovf_seen;
    pkt_ready = 1'b0;
    send_frame(8'h11, 8'h12, 8'h01, 16'h1234);
    pad(16);
    send_frame(8'h22, 8'h23, 8'h02, 16'h5678);
    pad(16);
    check("bp_valid_held", 40'(pkt_valid), 40'd1);
    check("bp_pkt_held", {pkt_src, pkt_dst, pkt_stype, pkt_data}, 40'h11_12_01_1234);
    check("bp_ovf_pulses", 40'(ovf_seen - ovf_base), 40'd1);
    check("bp_err", 40'(err_cnt), 40'd1);
    check("bp_frame_cnt", 40'(frame_cnt), 40'd1);

    // Accept on the CHECK edge: new packet loads, no overflow
    send_frame(8'h33, 8'h34, 8'h03, 16'h9ABC);
    pkt_ready = 1'b1;
    send_bit(1'b0);
    check("same_edge_valid", 40'(pkt_valid), 40'd1);
    check("same_edge_pkt", {pkt_src, pkt_dst, pkt_stype, pkt_data}, 40'h33_34_03_9ABC);
    check("same_edge_ovf", 40'(overflow), 40'd0);
    check("same_edge_frame_cnt", 40'(frame_cnt), 40'd2);
    send_bit(1'b0);
    check("bp_release_clear", 40'(pkt_valid), 40'd0);
    check("bp_err_final", 40'(err_cnt), 40'd1);

    // Reset during DST byte, then a clean frame
    pkt_ready = 1'b0;
    send_byte(8'hAB);
    send_byte(8'h28);
    send_byte(8'h55);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    reset = 1'b1;
    send_bit(1'b0);
    reset = 1'b0;
    check("midrst_outputs", {pkt_src, pkt_dst, pkt_stype, pkt_data}, 40'd0);
    check("midrst_counts", {24'd0, frame_cnt, err_cnt}, 40'd0);
    check("midrst_flags", {38'd0, pkt_valid, overflow}, 40'd0);
    pad(16);
    pkt_ready = 1'b1;
    base = cap_q.size();
    send_frame(8'h44, 8'h45, 8'h05, 16'h0102);
    pad(8);
    check("midrst_frame_cnt", 40'(frame_cnt), 40'd1);
    if (cap_q.size() > base) check("midrst_pkt", cap_q[base], 40'h44_45_05_0102);
    else check("midrst_count", 40'(cap_q.size() - base), 40'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
